// File: rtl/aurora_broadcast_replicator.sv
// Purpose : store-and-forward replicator; one AXI-Stream packet (header + payload) is buffered,
//           then replayed unchanged to one Aurora lane or to every lane (broadcast) in ascending order.
// Latency : first header beat valid on the 2nd rising edge after the final input beat is accepted;
//           then one beat per cycle, at most one idle cycle between lanes.
// Backpressure: input_r_TREADY is low during replay; a stalled lane holds its beat and blocks later lanes.
//
// Ports:
//   user_clk, peripheral_reset           clock, synchronous active-high reset
//   input_r_TDATA/TVALID/TLAST/TREADY    inbound packet stream
//   out_TDATA/TVALID/TLAST/TREADY        per-lane outbound streams, lane i at bits [32i+31:32i]
//   pkt_dropped                          one-cycle pulse for every discarded packet
//   drop_count, sent_count               saturating drop counter, wrapping lane-packet counter
module aurora_broadcast_replicator #(
  parameter int         NUM_LANES         = 4,
  parameter int         MAX_PAYLOAD_WORDS = 256,
  parameter logic [7:0] LANE_UID_BASE     = 8'h01,
  parameter logic [7:0] BCAST_UID         = 8'hFF
) (
  input  logic                      user_clk,
  input  logic                      peripheral_reset,
  input  logic [31:0]               input_r_TDATA,
  input  logic                      input_r_TVALID,
  input  logic                      input_r_TLAST,
  output logic                      input_r_TREADY,
  output logic [32*NUM_LANES-1:0]   out_TDATA,
  output logic [NUM_LANES-1:0]      out_TVALID,
  output logic [NUM_LANES-1:0]      out_TLAST,
  input  logic [NUM_LANES-1:0]      out_TREADY,
  output logic                      pkt_dropped,
  output logic [15:0]               drop_count,
  output logic [15:0]               sent_count
);

  localparam int          AW    = (MAX_PAYLOAD_WORDS > 1) ? $clog2(MAX_PAYLOAD_WORDS) : 1;
  localparam int          LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [16:0] MAX_W = 17'(MAX_PAYLOAD_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DROP,
    S_SETUP,
    S_SEND
  } state_t;

  state_t               r_state;
  logic                 r_in_rdy;
  logic [31:0]          r_hdr;
  logic [NUM_LANES-1:0] r_mask;
  logic [16:0]          r_w;        // payload words of the held packet
  logic [16:0]          r_idx;      // next buffer write index while loading
  logic [16:0]          r_rem;      // payload beats still to follow the beat on the lane
  logic [LW-1:0]        r_lane;
  logic                 r_vld;
  logic                 r_last;
  logic [31:0]          r_dat;
  logic                 r_drop;
  logic [15:0]          r_drop_cnt;
  logic [15:0]          r_sent_cnt;

  logic [31:0]          r_mem [MAX_PAYLOAD_WORDS];
  logic [AW-1:0]        r_rd_ptr;   // address of the word currently held in r_rd_dat
  logic [31:0]          r_rd_dat;

  // Header decode, valid only while a header beat is on the input
  logic [7:0]           w_uid;
  logic [16:0]          w_words;
  logic [8:0]           w_uid_off;
  logic                 w_is_bcast;
  logic                 w_in_range;
  logic [NUM_LANES-1:0] w_hdr_mask;
  logic                 w_hdr_bad;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_load_last;
  logic                 w_drop_now;
  logic [LW-1:0]        w_first;
  logic [LW-1:0]        w_next;
  logic                 w_next_vld;
  logic                 w_rd_en;
  logic [AW-1:0]        w_rd_addr;
  logic                 w_wr_en;

  assign w_uid      = input_r_TDATA[31:24];
  assign w_words    = ({1'b0, input_r_TDATA[15:0]} + 17'd3) >> 2;
  // Bit 8 is the borrow: set when the UID lies below the lane range
  assign w_uid_off  = {1'b0, w_uid} - {1'b0, LANE_UID_BASE};
  assign w_is_bcast = (w_uid == BCAST_UID);
  assign w_in_range = !w_uid_off[8] && (w_uid_off[7:0] < 8'(NUM_LANES));
  assign w_hdr_mask = w_is_bcast ? '1 :
                      w_in_range ? (NUM_LANES'(1) << w_uid_off[7:0]) : '0;
  assign w_hdr_bad  = !(w_is_bcast || w_in_range) || (w_words > MAX_W);

  assign w_in_fire   = input_r_TVALID && r_in_rdy;
  assign w_out_fire  = r_vld && out_TREADY[r_lane];
  assign w_load_last = ((r_idx + 17'd1) == r_w);

  // A drop is decided either on the header or on the beat that breaks the length contract
  always_comb begin
    w_drop_now = 1'b0;
    if (w_in_fire) begin
      if (r_state == S_IDLE)
        w_drop_now = w_hdr_bad ||
                     ((w_words == 17'd0) && !input_r_TLAST) ||
                     ((w_words != 17'd0) && input_r_TLAST);
      else if (r_state == S_LOAD)
        w_drop_now = (input_r_TLAST != w_load_last);
    end
  end

  // Lowest masked lane, and lowest masked lane above the current one
  always_comb begin
    w_first    = '0;
    w_next     = '0;
    w_next_vld = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_first = LW'(i);
        if (i > int'(r_lane)) begin
          w_next     = LW'(i);
          w_next_vld = 1'b1;
        end
      end
    end
  end

  // Prefetch: r_rd_dat always holds the next payload word to present. Address 0 is primed
  // before each lane's header so payload follows the header without a bubble.
  always_comb begin
    w_rd_en   = (r_state == S_SETUP) || ((r_state == S_SEND) && w_out_fire);
    w_rd_addr = '0;
    if ((r_state == S_SEND) && (r_rem != 17'd0))
      w_rd_addr = r_rd_ptr + AW'(1);
  end

  assign w_wr_en = (r_state == S_LOAD) && w_in_fire;

  always_ff @(posedge user_clk) begin
    if (w_wr_en)
      r_mem[r_idx[AW-1:0]] <= input_r_TDATA;
    if (w_rd_en) begin
      r_rd_dat <= r_mem[w_rd_addr];
      r_rd_ptr <= w_rd_addr;
    end
  end

  always_ff @(posedge user_clk) begin
    if (peripheral_reset) begin
      r_state    <= S_IDLE;
      r_in_rdy   <= 1'b0;
      r_hdr      <= '0;
      r_mask     <= '0;
      r_w        <= '0;
      r_idx      <= '0;
      r_rem      <= '0;
      r_lane     <= '0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_dat      <= '0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
      r_sent_cnt <= '0;
    end else begin
      r_drop <= w_drop_now;
      if (w_drop_now && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          r_in_rdy <= 1'b1;
          if (w_in_fire) begin
            r_hdr  <= input_r_TDATA;
            r_mask <= w_hdr_mask;
            r_w    <= w_words;
            r_idx  <= '0;
            if (w_hdr_bad) begin
              r_state <= input_r_TLAST ? S_IDLE : S_DROP;
            end else if (w_words == 17'd0) begin
              if (input_r_TLAST) begin
                r_state  <= S_SETUP;
                r_in_rdy <= 1'b0;
              end else begin
                r_state <= S_DROP;
              end
            end else if (!input_r_TLAST) begin
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (w_in_fire) begin
            r_idx <= r_idx + 17'd1;
            if (input_r_TLAST) begin
              if (w_load_last) begin
                r_state  <= S_SETUP;
                r_in_rdy <= 1'b0;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (w_load_last) begin
              r_state <= S_DROP;
            end
          end
        end

        S_DROP: begin
          if (w_in_fire && input_r_TLAST)
            r_state <= S_IDLE;
        end

        // One settle cycle while the buffer read of word 0 is primed
        S_SETUP: begin
          r_lane  <= w_first;
          r_vld   <= 1'b0;
          r_state <= S_SEND;
        end

        S_SEND: begin
          if (!r_vld) begin
            r_dat  <= r_hdr;
            r_last <= (r_w == 17'd0);
            r_rem  <= r_w;
            r_vld  <= 1'b1;
          end else if (w_out_fire) begin
            if (r_rem != 17'd0) begin
              r_dat  <= r_rd_dat;
              r_last <= (r_rem == 17'd1);
              r_rem  <= r_rem - 17'd1;
            end else begin
              r_sent_cnt <= r_sent_cnt + 16'd1;
              r_vld      <= 1'b0;
              r_last     <= 1'b0;
              if (w_next_vld) begin
                r_lane <= w_next;
              end else begin
                r_state  <= S_IDLE;
                r_in_rdy <= 1'b1;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Only the lane being served sees the beat register; all others read zero
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic w_sel;
    assign w_sel                 = (r_lane == LW'(g));
    assign out_TVALID[g]         = r_vld && w_sel;
    assign out_TLAST[g]          = r_vld && r_last && w_sel;
    assign out_TDATA[32*g +: 32] = w_sel ? r_dat : 32'd0;
  end

  assign input_r_TREADY = r_in_rdy;
  assign pkt_dropped    = r_drop;
  assign drop_count     = r_drop_cnt;
  assign sent_count     = r_sent_cnt;

endmodule

// File: tb/tb_aurora_broadcast_replicator.sv
// Purpose : self-checking bench for aurora_broadcast_replicator; directed scenarios then random packets
//           against a packet-level reference model.
// Latency : checks first-beat timing on a unicast packet.
// Backpressure: drives per-lane ready all-high, with a forced lane-1 stall, or randomly.
module tb_aurora_broadcast_replicator;

  localparam int NL   = 4;
  localparam int MAXW = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       in_dat;
  logic              in_vld;
  logic              in_last;
  logic              in_rdy;
  logic [32*NL-1:0]  o_dat;
  logic [NL-1:0]     o_vld;
  logic [NL-1:0]     o_last;
  logic [NL-1:0]     o_rdy = '1;
  logic              drop;
  logic [15:0]       dcnt;
  logic [15:0]       scnt;

  always #5 clk = ~clk;

  aurora_broadcast_replicator #(
    .NUM_LANES(NL), .MAX_PAYLOAD_WORDS(MAXW), .LANE_UID_BASE(8'h01), .BCAST_UID(8'hFF)
  ) dut (
    .user_clk(clk), .peripheral_reset(rst),
    .input_r_TDATA(in_dat), .input_r_TVALID(in_vld), .input_r_TLAST(in_last), .input_r_TREADY(in_rdy),
    .out_TDATA(o_dat), .out_TVALID(o_vld), .out_TLAST(o_last), .out_TREADY(o_rdy),
    .pkt_dropped(drop), .drop_count(dcnt), .sent_count(scnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int drop_model = 0, sent_model = 0, drop_pulses = 0;
  int stall_seen = 0;
  int rdy_mode = 0, l1_beats = 0, hold_cnt = 0;
  bit gaps = 0;

  // Entries are {lane[3:0], last, data}
  logic [36:0] act_q[$];
  logic [36:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: a packet is delivered iff its UID is known, it fits the buffer
  // and exactly W payload beats precede TLAST; delivery is header+payload per selected lane.
  function automatic void model_pkt(input logic [31:0] hdr, input int n, input logic [31:0] pay[$]);
    int w;
    int uid;
    bit ok;
    w   = (int'(hdr[15:0]) + 3) / 4;
    uid = int'(hdr[31:24]);
    ok  = (uid == 255 || (uid >= 1 && uid <= NL)) && (w <= MAXW) && (n == w);
    if (!ok) begin
      drop_model++;
      return;
    end
    for (int l = 0; l < NL; l++) begin
      if (uid == 255 || uid == l + 1) begin
        exp_q.push_back({4'(l), (w == 0), hdr});
        for (int k = 0; k < w; k++)
          exp_q.push_back({4'(l), (k == w - 1), pay[k]});
        sent_model++;
      end
    end
  endfunction

  // Output monitor: records handshakes, checks hold-while-stalled and one-lane-at-a-time
  logic [NL-1:0] pend = '0;
  logic [31:0]   pdat [NL];
  logic          plast[NL];

  always @(negedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (o_vld != '0)
        chk("one_lane_active", 64'($countones(o_vld)), 64'd1);
      for (int i = 0; i < NL; i++) begin
        if (pend[i]) begin
          chk($sformatf("hold_vld_l%0d", i), o_vld[i], 1'b1);
          chk($sformatf("hold_dat_l%0d", i), {o_last[i], o_dat[32*i +: 32]}, {plast[i], pdat[i]});
        end
        if (o_vld[i] && o_rdy[i]) begin
          act_q.push_back({4'(i), o_last[i], o_dat[32*i +: 32]});
          if (i == 1) l1_beats++;
        end
        pend[i]  <= o_vld[i] && !o_rdy[i];
        pdat[i]  <= o_dat[32*i +: 32];
        plast[i] <= o_last[i];
      end
      if (drop) drop_pulses++;
    end
  end

  // Lane-ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: o_rdy = '1;
      1: for (int i = 0; i < NL; i++) o_rdy[i] = ($urandom_range(0, 3) != 0);
      default: begin
        if (l1_beats >= 2 && hold_cnt < 10) begin
          o_rdy = 4'b1101;
          hold_cnt++;
        end else begin
          o_rdy = '1;
        end
      end
    endcase
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int tries = 0;
    if (gaps && $urandom_range(0, 7) == 0) begin
      in_vld = 1'b0;
      tick();
    end
    in_dat  = d;
    in_last = l;
    in_vld  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_rdy) begin
        tick();
        break;
      end
      stall_seen++;
      tries++;
      if (tries > 5000) begin
        chk("in_rdy_timeout", in_rdy, 1'b1);
        tick();
        break;
      end
      tick();
    end
    in_vld = 1'b0;
  endtask

  task automatic drive_pkt(input logic [31:0] hdr, input int n, input bit fixed_pay, input logic [31:0] pay_val);
    logic [31:0] pay[$];
    for (int k = 0; k < n; k++)
      pay.push_back(fixed_pay ? pay_val : 32'($urandom()));
    model_pkt(hdr, n, pay);
    send_beat(hdr, n == 0);
    for (int k = 0; k < n; k++)
      send_beat(pay[k], k == n - 1);
  endtask

  task automatic finish_pkt(input string tag);
    int cyc = 0;
    while ((act_q.size() < exp_q.size() || !in_rdy) && cyc < 4000) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, in_rdy, 1'b1);
    repeat (3) tick();
    chk({tag, "_beats"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), act_q[i], exp_q[i]);
    chk({tag, "_drop_count"}, dcnt, 64'(drop_model));
    chk({tag, "_sent_count"}, scnt, 64'(sent_model));
    chk({tag, "_drop_pulses"}, 64'(drop_pulses), 64'(drop_model));
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int c;
    logic [7:0]  uid;
    int          len, w, n, kind;
    logic [7:0]  unk[3];

    rst = 1'b1; in_vld = 1'b0; in_dat = '0; in_last = 1'b0;
    repeat (3) tick();
    chk("rst_tready", in_rdy, 1'b0);
    chk("rst_tvalid", o_vld, '0);
    chk("rst_tlast", o_last, '0);
    chk("rst_tdata", o_dat[63:0] | o_dat[127:64], '0);
    chk("rst_dropped", drop, 1'b0);
    chk("rst_drop_count", dcnt, '0);
    chk("rst_sent_count", scnt, '0);
    rst = 1'b0;
    tick();
    chk("idle_tready", in_rdy, 1'b1);

    // Broadcast, 216 payload words
    drive_pkt(32'hFF040360, 216, 1'b1, 32'h1);
    finish_pkt("bcast");

    // Unicast to lane 2 with first-beat timing
    drive_pkt(32'h03020008, 2, 1'b0, 32'h0);
    chk("lat_edge0", o_vld, 4'b0000);
    tick();
    chk("lat_edge1", o_vld, 4'b0000);
    tick();
    chk("lat_edge2", o_vld, 4'b0100);
    finish_pkt("ucast");

    // Unknown UID: dropped, ready never falls
    stall_seen = 0;
    drive_pkt(32'h40010004, 1, 1'b0, 32'h0);
    finish_pkt("unk_uid");
    chk("unk_tready_stalls", 64'(stall_seen), 64'd0);

    // Early TLAST then a clean unicast
    drive_pkt(32'h02010010, 2, 1'b0, 32'h0);
    finish_pkt("early_last");
    drive_pkt(32'h04010008, 2, 1'b0, 32'h0);
    finish_pkt("after_drop");

    // Lane 1 stalled mid-packet for 10 cycles
    l1_beats = 0;
    hold_cnt = 0;
    rdy_mode = 2;
    drive_pkt(32'hFF01000C, 3, 1'b0, 32'h0);
    finish_pkt("bp");
    rdy_mode = 0;

    // Reset during lane 1 replay
    drive_pkt(32'hFF010028, 10, 1'b0, 32'h0);
    c = 0;
    while (!o_vld[1] && c < 300) begin
      tick();
      c++;
    end
    chk("reach_lane1", o_vld[1], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tvalid", o_vld, '0);
    chk("midrst_drop_count", dcnt, '0);
    chk("midrst_sent_count", scnt, '0);
    act_q.delete();
    exp_q.delete();
    drop_model = 0;
    sent_model = 0;
    drop_pulses = 0;
    drive_pkt(32'h01030014, 5, 1'b0, 32'h0);
    finish_pkt("post_rst");

    // Random packets with random lane ready and input gaps
    rdy_mode = 1;
    gaps = 1;
    unk[0] = 8'h00; unk[1] = 8'h05; unk[2] = 8'h80;
    for (int p = 0; p < 25; p++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 2)      uid = 8'hFF;
      else if (kind <= 7) uid = 8'(1 + $urandom_range(0, NL - 1));
      else                uid = unk[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(1028, 3000);
        n   = $urandom_range(0, 4);
      end else begin
        len  = $urandom_range(0, 48);
        w    = (len + 3) / 4;
        kind = $urandom_range(0, 9);
        if (kind <= 6)      n = w;
        else if (kind == 7) n = (w > 0) ? w - 1 : 1;
        else if (kind == 8) n = w + 1;
        else                n = w + 2;
      end
      drive_pkt({uid, 8'($urandom_range(0, 255)), 16'(len)}, n, 1'b0, 32'h0);
      finish_pkt($sformatf("rnd%0d", p));
    end
    rdy_mode = 0;
    gaps = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_broadcast_replicator.md
Name: aurora_broadcast_replicator

Overview:
- Store-and-forward packet replicator between the PS AXI-Stream source (input_r) and the NUM_LANES Aurora TX streams.
- Accepts one packet: header word plus payload words.
- Decodes the header's RX_UID and replays the complete packet, unchanged, to one lane or to all lanes (broadcast).
- Malformed packets are dropped and counted. Replay to lanes is sequential, in ascending lane order.

Parameters:
- NUM_LANES, 4, number of Aurora output lanes (1..8).
- MAX_PAYLOAD_WORDS, 256, packet buffer depth in 32-bit payload words.
- LANE_UID_BASE, 8'h01, RX_UID of lane 0; lane i answers to LANE_UID_BASE+i.
- BCAST_UID, 8'hFF, RX_UID that selects all lanes.

Ports:
- user_clk  in  1  single clock for the whole block.
- peripheral_reset  in  1  synchronous, active-high reset.
- input_r_TDATA  in  32  inbound stream data.
- input_r_TVALID  in  1  inbound valid.
- input_r_TLAST  in  1  inbound end of packet.
- input_r_TREADY  out  1  inbound ready.
- out_TDATA  out  32*NUM_LANES  per-lane data; lane i is bits [32i+31:32i].
- out_TVALID  out  NUM_LANES  per-lane valid.
- out_TLAST  out  NUM_LANES  per-lane end of packet.
- out_TREADY  in  NUM_LANES  per-lane ready.
- pkt_dropped  out  1  one-cycle pulse when a packet is discarded.
- drop_count  out  16  dropped packets, saturating at 16'hFFFF.
- sent_count  out  16  lane-packets delivered, wraps at 16 bits.

Behaviour:
- Header format: [31:24] RX_UID, [23:16] TX_UID, [15:0] payload byte count LEN. Payload words W = ceil(LEN/4) = (LEN+3)>>2.
- Reset (synchronous, active-high) puts the block in IDLE and clears: input_r_TREADY, all out_TVALID, out_TLAST, out_TDATA, pkt_dropped, drop_count, sent_count. The buffer contents are don't-care.
- Reset asserted mid-packet aborts immediately. No partial packet is emitted afterwards, and the aborted packet is not counted.
- Handshakes are AXI-Stream: a transfer occurs when VALID and READY are both high on a rising edge. Once out_TVALID[i] is raised, it and out_TDATA/out_TLAST of lane i stay stable until out_TREADY[i].
- IDLE: input_r_TREADY=1. Header handshake: latch the header and compute the lane mask.
  - Mask = all ones if RX_UID==BCAST_UID.
  - Mask = one-hot(RX_UID-LANE_UID_BASE) if RX_UID lies in the lane UID range.
  - Otherwise the UID is unknown.
- Header acceptance paths:
  - Unknown UID or W>MAX_PAYLOAD_WORDS: go to DROP, or finish the drop that cycle if header TLAST=1.
  - W==0 with header TLAST=1: go to SEND.
  - W==0 with TLAST=0: drop; go to DROP.
  - W>0 with header TLAST=1: drop (short); return to IDLE.
  - W>0 with TLAST=0: go to LOAD.
- LOAD: input_r_TREADY=1. Each beat is written to buffer[idx] and idx increments.
  - TLAST on beat W: go to SEND.
  - TLAST on an earlier beat: drop; go to IDLE.
  - Beat W without TLAST: drop; go to DROP.
- DROP: input_r_TREADY=1. Discard beats until a TLAST handshake, then go to IDLE.
- Every drop pulses pkt_dropped for exactly one cycle, on the cycle the drop is decided, and increments drop_count.
- SEND: input_r_TREADY=0. Lanes in the mask are served one at a time, lowest index first. Unmasked lanes keep TVALID=0.
  - Current lane beats: the header, then buffer[0..W-1].
  - TLAST is on the final beat: the header itself when W==0.
  - First header beat: out_TVALID asserted on the 2nd rising edge after the cycle that accepted the final input beat.
  - Throughput: one beat per cycle while out_TREADY is held high.
  - Inter-lane gap: at most 1 idle cycle.
  - Each completed lane TLAST handshake increments sent_count.
  - After the last masked lane, return to IDLE. input_r_TREADY rises on the following cycle.
- Lane stall: out_TREADY low holds the current beat. Other lanes wait; no reordering.
- Buffer: single-port write / single-read RAM, depth MAX_PAYLOAD_WORDS. Read latency is hidden by prefetch so back-to-back beats need no bubbles.

Test Plan:
- Broadcast: header 32'hFF040360 plus 216 payload beats of 32'h1, TLAST on beat 216, all out_TREADY=1 → each of lanes 0..3 emits 217 beats in order 0,1,2,3, header first, TLAST on the 217th; sent_count=4; pkt_dropped never pulses.
- Unicast: header 32'h03020008 plus 2 beats (A,B) → only lane 2 emits {32'h03020008,A,B}, TLAST on B; sent_count=1; other lanes' TVALID stays 0.
- Unknown UID: header 32'h40010004 plus 1 beat with TLAST → no output on any lane; pkt_dropped pulses once; drop_count=1; input_r_TREADY stays 1 throughout.
- Early TLAST: LEN=16 (W=4), TLAST on 2nd payload beat → drop_count=1; no output. A following valid unicast packet is delivered intact.
- Backpressure: broadcast, LEN=12; out_TREADY[1] low for 10 cycles mid-packet → lane 1 data holds stable; lanes 2 and 3 start only after lane 1's TLAST; all 4 lanes deliver 4 beats each.
- Reset mid-SEND: assert peripheral_reset for 1 cycle during lane 1 replay → all out_TVALID=0 the next cycle; counters=0; the next packet is processed normally.
